// File: rtl/cache_nway_pkg.sv
// Shared types for the N-way line cache: address/line widths and controller states.
package cache_nway_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_memband;

   typedef enum logic [1:0] {
      CHECK,
      WRITEBACK,
      ALLOCATE
   } lc3b_cache_state;

   function automatic lc3b_word line_addr(input lc3b_word a);
      return a & 16'hFFF0;
   endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Tree pseudo-LRU for one set: victim walk over the current bits and the bit
// update for an access to i_way.
module plru_tree #(
   parameter  int WAYS  = 2,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  i_bits,
   input  logic [WAY_W-1:0] i_way,
   output logic [WAY_W-1:0] o_victim,
   output logic [WAYS-2:0]  o_next_bits
);

   logic [7:0]  w_pad_bits;
   logic [31:0] w_way32;
   logic        w_v2;
   logic        w_v1;
   logic        w_v0;

   // Walk an 8-way tree; narrower trees take the top WAY_W bits of the path.
   assign w_pad_bits = 8'(i_bits);
   assign w_v2       = w_pad_bits[0];
   assign w_v1       = w_v2 ? w_pad_bits[2] : w_pad_bits[1];
   assign w_v0       = w_pad_bits[{1'b0, w_v2, w_v1} + 3'd3];
   assign o_victim   = WAY_W'({w_v2, w_v1, w_v0} >> (3 - WAY_W));

   assign w_way32 = 32'(i_way);

   for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
      localparam int          D = $clog2(n + 2) - 1;
      localparam int unsigned P = n + 1 - (1 << D);
      assign o_next_bits[n] = ((w_way32 >> (WAY_W - D)) == P) ? ~i_way[WAY_W-1-D] : i_bits[n];
   end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate line cache with its
// controller FSM between a line requester and physical memory.
//
// state     | meaning
// CHECK     | lookup; hits complete here, misses pick a victim
// WRITEBACK | dirty victim being written to pmem
// ALLOCATE  | fill line being read from pmem into the victim way
module cache_nway
   import cache_nway_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int SETS_LOG2 = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int SETS  = 1 << SETS_LOG2;
   localparam int TAG_W = 12 - SETS_LOG2;
   localparam int WAY_W = $clog2(WAYS);

   lc3b_cache_state   r_state;
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [WAYS-2:0]   r_plru  [SETS];
   logic [WAY_W-1:0]  r_victim;

   logic [SETS_LOG2-1:0] w_index;
   logic [TAG_W-1:0]     w_tag;
   logic [TAG_W-1:0]     w_way_tag  [WAYS];
   lc3b_memband          w_way_data [WAYS];
   logic [WAYS-1:0]      w_hit_vec;
   logic [WAYS-1:0]      w_set_valid;
   logic [WAYS-1:0]      w_set_dirty;
   logic                 w_req;
   logic                 w_hit;
   logic                 w_hit_wr;
   logic                 w_fill;
   logic [WAY_W-1:0]     w_hit_way;
   logic [WAY_W-1:0]     w_victim;
   logic [WAY_W-1:0]     w_plru_victim;
   logic [WAYS-2:0]      w_plru_next;

   assign w_index     = mem_address[4+SETS_LOG2-1:4];
   assign w_tag       = mem_address[15:4+SETS_LOG2];
   assign w_set_valid = r_valid[w_index];
   assign w_set_dirty = r_dirty[w_index];
   assign w_req       = mem_read | mem_write;
   assign w_hit       = |w_hit_vec;
   assign w_hit_wr    = (r_state == CHECK) & mem_write & w_hit;
   assign w_fill      = (r_state == ALLOCATE) & pmem_resp;

   // Tag and data storage carry no reset; valid bits gate every use.
   for (genvar g = 0; g < WAYS; g++) begin : g_way
      logic [TAG_W-1:0] r_tag  [SETS];
      lc3b_memband      r_data [SETS];

      always_ff @(posedge clk) begin
         if (w_fill && (r_victim == WAY_W'(g))) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= pmem_rdata;
         end else if (w_hit_wr && (w_hit_way == WAY_W'(g))) begin
            r_data[w_index] <= mem_wdata;
         end
      end

      assign w_way_tag[g]  = r_tag[w_index];
      assign w_way_data[g] = r_data[w_index];
      assign w_hit_vec[g]  = w_set_valid[g] && (r_tag[w_index] == w_tag);
   end

   always_comb begin
      w_hit_way = '0;
      w_victim  = w_plru_victim;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
         if (!w_set_valid[i]) w_victim = WAY_W'(i);
      end
   end

   plru_tree #(.WAYS(WAYS)) u_plru (
      .i_bits      (r_plru[w_index]),
      .i_way       (w_hit_way),
      .o_victim    (w_plru_victim),
      .o_next_bits (w_plru_next)
   );

   assign mem_resp  = (r_state == CHECK) & w_req & w_hit;
   assign mem_rdata = w_way_data[w_hit_way];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= CHECK;
         r_victim     <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_plru[s]  <= '0;
         end
      end else begin
         case (r_state)
            CHECK: begin
               if (w_req) begin
                  if (w_hit) begin
                     r_plru[w_index] <= w_plru_next;
                     if (mem_write) r_dirty[w_index][w_hit_way] <= 1'b1;
                  end else begin
                     r_victim <= w_victim;
                     if (w_set_valid[w_victim] && w_set_dirty[w_victim]) begin
                        r_state      <= WRITEBACK;
                        pmem_write   <= 1'b1;
                        pmem_address <= {w_way_tag[w_victim], w_index, 4'h0};
                        pmem_wdata   <= w_way_data[w_victim];
                     end else begin
                        r_state      <= ALLOCATE;
                        pmem_read    <= 1'b1;
                        pmem_address <= line_addr(mem_address);
                     end
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  r_state      <= ALLOCATE;
                  pmem_write   <= 1'b0;
                  pmem_read    <= 1'b1;
                  pmem_address <= line_addr(mem_address);
               end
            end
            ALLOCATE: begin
               // The retry in CHECK hits and performs the PLRU update and any write.
               if (pmem_resp) begin
                  r_state                     <= CHECK;
                  pmem_read                   <= 1'b0;
                  r_valid[w_index][r_victim]  <= 1'b1;
                  r_dirty[w_index][r_victim]  <= 1'b0;
               end
            end
            default: r_state <= CHECK;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway (WAYS=4, SETS_LOG2=3) against a flat
// golden memory plus per-transaction expectations for pmem traffic and latency.
module tb_cache_nway;

   localparam int WAYS      = 4;
   localparam int SETS_LOG2 = 3;
   localparam int HIT       = 0;
   localparam int CLEAN     = 1;
   localparam int DIRTY     = 2;

   logic         clk;
   logic         reset;
   logic         mem_read;
   logic         mem_write;
   logic [15:0]  mem_address;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   cache_nway #(.WAYS(WAYS), .SETS_LOG2(SETS_LOG2)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           rst;
      bit           rd;
      bit           wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      int           kind;
      logic [15:0]  wb_addr;
      int           dly;
   } vec_t;

   int           checks;
   int           errors;
   logic [127:0] sb_q [$];
   logic [127:0] gold  [logic [15:0]];
   logic [127:0] store [logic [15:0]];
   vec_t         vecs [$];

   localparam logic [127:0] LINE_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
   localparam logic [127:0] LINE_B = 128'hB00B_1111_B00B_2222_B00B_3333_B00B_4444;

   function automatic logic [127:0] init_line(input logic [15:0] a);
      return {a, ~a, a ^ 16'h5A5A, a + 16'd1, a, ~a, a ^ 16'hA5A5, a + 16'd7};
   endfunction

   function automatic logic [127:0] gold_get(input logic [15:0] a);
      if (gold.exists(a)) return gold[a];
      return init_line(a);
   endfunction

   function automatic logic [127:0] store_get(input logic [15:0] a);
      if (store.exists(a)) return store[a];
      return init_line(a);
   endfunction

   function automatic vec_t mk(input bit rst, input bit rd, input bit wr, input logic [15:0] a,
                               input logic [127:0] wd, input int kind, input logic [15:0] wb,
                               input int dly);
      vec_t v;
      v.rst = rst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
      v.kind = kind; v.wb_addr = wb; v.dly = dly;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_pmem_address", pmem_address, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_mem_resp", mem_resp, 0);
      chk("post_rst_pmem_read", pmem_read, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input int idx, input vec_t v);
      logic [15:0]  line;
      logic [15:0]  wb_a;
      logic [15:0]  rd_a;
      logic [127:0] wb_d;
      logic [127:0] exp_d;
      logic [127:0] wb_exp;
      bit           saw_wb;
      bit           saw_rd;
      bit           done;
      int           cyc;
      int           hold;
      int           exp_cyc;
      line   = v.addr & 16'hFFF0;
      wb_exp = gold_get(v.wb_addr);
      sb_q.push_back(gold_get(line));
      if (v.wr) gold[line] = v.wdata;
      wb_a = '0; rd_a = '0; wb_d = '0;
      saw_wb = 1'b0; saw_rd = 1'b0; done = 1'b0; cyc = 0; hold = 0;
      mem_read    = v.rd;
      mem_write   = v.wr;
      mem_address = v.addr;
      mem_wdata   = v.wdata;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         chk($sformatf("v%0d_pmem_exclusive", idx), pmem_read & pmem_write, 0);
         if (mem_resp) begin
            if (sb_q.size() == 0) begin
               chk($sformatf("v%0d_sb_underflow", idx), 1, 0);
            end else begin
               exp_d = sb_q.pop_front();
               if (!v.wr) chk($sformatf("v%0d_rdata", idx), mem_rdata, exp_d);
            end
            done = 1'b1;
         end else if (pmem_read || pmem_write) begin
            if (hold < v.dly) begin
               hold++;
            end else begin
               hold = 0;
               if (pmem_write) begin
                  saw_wb = 1'b1;
                  wb_a   = pmem_address;
                  wb_d   = pmem_wdata;
                  store[pmem_address] = pmem_wdata;
               end else begin
                  saw_rd     = 1'b1;
                  rd_a       = pmem_address;
                  pmem_rdata = store_get(pmem_address);
               end
               pmem_resp = 1'b1;
            end
         end
         @(posedge clk);
         #1 pmem_resp = 1'b0;
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (v.kind)
         HIT:     exp_cyc = 1;
         CLEAN:   exp_cyc = 3 + v.dly;
         default: exp_cyc = 4 + 2 * v.dly;
      endcase
      chk($sformatf("v%0d_completed", idx), done, 1);
      chk($sformatf("v%0d_latency", idx), cyc, exp_cyc);
      chk($sformatf("v%0d_writeback_seen", idx), saw_wb, v.kind == DIRTY);
      chk($sformatf("v%0d_fill_seen", idx), saw_rd, v.kind != HIT);
      if (saw_rd) chk($sformatf("v%0d_fill_addr", idx), rd_a, line);
      if (saw_wb) begin
         chk($sformatf("v%0d_wb_addr", idx), wb_a, v.wb_addr);
         chk($sformatf("v%0d_wb_data", idx), wb_d, wb_exp);
      end
   endtask

   initial begin
      bit found;
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      pmem_rdata  = '0;
      pmem_resp   = 1'b0;

      vecs.push_back(mk(1, 1, 0, 16'h1230, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h1230, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(1, 1, 0, 16'h0000, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0080, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0100, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0180, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0000, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0200, '0,     CLEAN, 16'h0000, 2));
      vecs.push_back(mk(0, 1, 0, 16'h0000, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0080, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0180, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0100, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(1, 0, 1, 16'h0000, LINE_A, CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0080, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0100, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0180, '0,     CLEAN, 16'h0000, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0200, '0,     DIRTY, 16'h0000, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0000, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h1230, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 1, 16'h1230, LINE_B, HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h1230, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0030, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h00B0, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0130, '0,     CLEAN, 16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h01B0, '0,     DIRTY, 16'h1230, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0030, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h00B0, '0,     HIT,   16'h0000, 0));
      vecs.push_back(mk(0, 1, 0, 16'h0130, '0,     HIT,   16'h0000, 0));

      foreach (vecs[i]) begin
         if (vecs[i].rst) apply_reset();
         run_req(i, vecs[i]);
      end

      // Reset while a fill is outstanding: strobes drop at once, lines are lost.
      mem_read    = 1'b1;
      mem_address = 16'h0600;
      found       = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (pmem_read) found = 1'b1;
      end
      chk("abort_alloc_reached", found, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_pmem_read", pmem_read, 0);
      chk("abort_pmem_write", pmem_write, 0);
      chk("abort_mem_resp", mem_resp, 0);
      mem_read = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      run_req(100, mk(0, 1, 0, 16'h0030, '0, CLEAN, 16'h0000, 0));

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate line cache with an integrated controller FSM. It generalises the fixed 2-way datapath to 2/4/8 ways and a configurable set count, and replaces single-bit LRU with tree pseudo-LRU. It sits between a line-granular requester (L1 or arbiter) and physical memory, and transfers whole 128-bit lines on both sides.

## Interface
- WAYS, default 2: associativity; legal values are 2, 4 and 8.
- SETS_LOG2, default 3: index width. Offset is fixed at 4 bits. Tag width is 12-SETS_LOG2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high. Clears valid, dirty and PLRU state, and forces the FSM to CHECK.
- mem_read  in  1  line read request; held until mem_resp.
- mem_write  in  1  line write request; held until mem_resp. If asserted together with mem_read, the request is treated as a write.
- mem_address  in  16  byte address; bits [3:0] ignored; held stable until mem_resp.
- mem_wdata  in  128  write line.
- mem_rdata  out  128  line from the hitting way; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse; reset value 0.
- pmem_read / pmem_write  out  1  memory requests; reset value 0; held until pmem_resp.
- pmem_address  out  16  line-aligned address; reset value 0.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line; sampled when pmem_resp=1.
- pmem_resp  in  1  memory completion; ignored in CHECK.

## Operation
- Per way, per set: tag, 128-bit data, valid bit, dirty bit. Per set: WAYS-1 PLRU bits.
- Address fields: index = mem_address[4+SETS_LOG2-1:4]; tag = mem_address[15:4+SETS_LOG2].
- Hit: valid & tag equal in exactly one way. Array reads are combinational.
- FSM states: CHECK, WRITEBACK, ALLOCATE.
  - CHECK, request, hit:
    - assert mem_resp and drive mem_rdata from the hitting way;
    - update PLRU;
    - on write: store mem_wdata and set dirty;
    - stay in CHECK.
  - CHECK, request, miss: select victim. If victim valid&dirty, go to WRITEBACK; else go to ALLOCATE.
  - Victim selection: the lowest-index invalid way; if all ways are valid, the PLRU victim. The victim is latched on entry to WRITEBACK/ALLOCATE.
  - WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim data. On pmem_resp, go to ALLOCATE.
  - ALLOCATE: pmem_read=1, pmem_address={mem_address[15:4], 4'h0}. On pmem_resp: write pmem_rdata into victim, tag=request tag, valid=1, dirty=0; go to CHECK. The retry then hits; the PLRU update and any write happen on that hit.
- PLRU tree: node 0 is the root; children of node n are 2n+1 and 2n+2; leaves map to ways in order.
  - Victim walk: bit 0 selects the lower half, bit 1 the upper half.
  - Access to way w: every node on w's path points away from w.
  - With WAYS=2 this reduces to true LRU.
- Reset mid-operation: the FSM returns to CHECK, pmem strobes drop asynchronously, all lines become invalid, and any outstanding transaction is abandoned.

## Timing
- Hit latency: mem_resp in the same cycle the request is presented in CHECK.
- Clean miss: 1 CHECK cycle, then ALLOCATE until pmem_resp, then 1 CHECK cycle with mem_resp.
- Dirty miss: adds the WRITEBACK phase before ALLOCATE.
- Minimum gap: with pmem_resp in the first cycle of each phase, a clean miss completes in 3 cycles and a dirty miss in 4.
- Back-to-back hits: one per cycle; no dead cycle after mem_resp.
- pmem_read and pmem_write are never asserted together.

## Structure
- lc3b_types: reuse lc3b_word and lc3b_memband. Add the lc3b_cache_state enum {CHECK, WRITEBACK, ALLOCATE}.
- Tag and index widths are localparams derived from SETS_LOG2; they stay out of the package.
- Generate loop over WAYS instantiating the existing array module for tag and data.
- Valid, dirty and PLRU are local flop arrays, because they need asynchronous reset.
- One new sub-module, plru_tree #(WAYS): combinational; inputs are the PLRU bits and the accessed way; outputs are the victim way and the next PLRU bits.

## Test plan
WAYS=4, SETS_LOG2=3 throughout.

1. Reset, then read 0x1230. Required: pmem_read with pmem_address 0x1230; pmem_resp with line D; next cycle mem_resp=1, mem_rdata=D. pmem_write never asserts.
2. Repeat read 0x1230. Required: mem_resp in the same cycle, mem_rdata=D, no pmem activity.
3. Reset, then read 0x0000, 0x0080, 0x0100, 0x0180 (fills ways 0–3), then read 0x0000, then read 0x0200. Required: way 2 (0x0100) is replaced with no writeback; a following read of 0x0100 misses.
4. Reset; write 0x0000 with line A; then read 0x0080, 0x0100, 0x0180; then read 0x0200. Required: pmem_write with address 0x0000 and wdata=A, then pmem_read 0x0200, then mem_resp.
5. Assert reset while in ALLOCATE. Required: pmem_read=0 and mem_resp=0 immediately; a subsequent read of a previously cached address misses.
6. mem_read=mem_write=1 at 0x1230 (line resident), mem_wdata=B. Required: treated as a write; a later read of 0x1230 returns B and the line is dirty (eviction writes back B).
